// File: rtl/sum_bcd_display_if.sv
// Interface carrying the load request and the converted display result of
// sum_bcd_display. Signal prefixes are from the point of view of the converter.
interface sum_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  i_load;
    logic [WIDTH-1:0]      i_value;
    logic                  i_signed;
    logic                  i_ovf;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_neg;
    logic [4*DIGITS-1:0]   o_bcd;
    logic [6:0]            o_hex0;
    logic [6:0]            o_hex1;
    logic [6:0]            o_hex2;
    logic [6:0]            o_hex3;

    // Producer side: the adder/subtractor result register feeding the display.
    modport master (
        output i_load, i_value, i_signed, i_ovf,
        input  o_busy, o_done, o_neg, o_bcd, o_hex0, o_hex1, o_hex2, o_hex3
    );

    // Converter side.
    modport slave (
        input  i_load, i_value, i_signed, i_ovf,
        output o_busy, o_done, o_neg, o_bcd, o_hex0, o_hex1, o_hex2, o_hex3
    );
endinterface

// File: rtl/sum_bcd_display.sv
// Captures an adder result on Load, converts it to sign + magnitude BCD with a
// serial double-dabble (one bit per cycle) and drives four active-low
// seven-segment displays. Outputs only ever change at the edge entering DONE,
// so a partially converted value is never visible.
module sum_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sum_bcd_display_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_SHIFT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_value;
    logic              r_signed;
    logic              r_ovf;
    logic [WIDTH-1:0]  r_mag;
    logic              r_neg_int;
    logic [BW-1:0]     r_bcd_sr;
    logic [CW-1:0]     r_cnt;

    logic              r_neg;
    logic [BW-1:0]     r_bcd;
    logic [6:0]        r_hex0;
    logic [6:0]        r_hex1;
    logic [6:0]        r_hex2;
    logic [6:0]        r_hex3;

    logic [BW-1:0]     w_bcd_adj;
    logic [BW-1:0]     w_bcd_shift;
    logic              w_last;

    // Segment pattern {g..a}, active low, for a decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: every digit >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd_sr[4*gi +: 4] >= 4'd5)
                                        ? r_bcd_sr[4*gi +: 4] + 4'd3
                                        : r_bcd_sr[4*gi +: 4];
        end
    endgenerate

    assign w_bcd_shift = {w_bcd_adj[BW-2:0], r_mag[WIDTH-1]};
    assign w_last      = (r_cnt == CW'(1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> PREP -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_load) w_state_next = S_PREP;
            S_PREP:  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Capture, conversion datapath and publication of the result. The result
    // registers load on the final shift, i.e. the edge that enters DONE, so
    // they are valid for the whole Done cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value   <= '0;
            r_signed  <= 1'b0;
            r_ovf     <= 1'b0;
            r_mag     <= '0;
            r_neg_int <= 1'b0;
            r_bcd_sr  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_bcd     <= '0;
            r_hex0    <= SEG_ZERO;
            r_hex1    <= SEG_BLANK;
            r_hex2    <= SEG_BLANK;
            r_hex3    <= SEG_BLANK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_load) begin
                        r_value  <= bus.i_value;
                        r_signed <= bus.i_signed;
                        r_ovf    <= bus.i_ovf;
                    end
                end
                S_PREP: begin
                    // Negating 8'h80 yields 8'h80, which read unsigned is the
                    // correct magnitude 128, so WIDTH bits are enough here.
                    if (r_signed && r_value[WIDTH-1]) begin
                        r_mag     <= (~r_value) + 1'b1;
                        r_neg_int <= 1'b1;
                    end else begin
                        r_mag     <= r_value;
                        r_neg_int <= 1'b0;
                    end
                    r_bcd_sr <= '0;
                    r_cnt    <= CW'(WIDTH);
                end
                S_SHIFT: begin
                    r_bcd_sr <= w_bcd_shift;
                    r_mag    <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt    <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_bcd  <= w_bcd_shift;
                        r_neg  <= r_neg_int;
                        r_hex0 <= seg7(w_bcd_shift[3:0]);
                        r_hex1 <= (w_bcd_shift[11:4] == 8'd0) ? SEG_BLANK
                                                             : seg7(w_bcd_shift[7:4]);
                        r_hex2 <= (w_bcd_shift[11:8] == 4'd0) ? SEG_BLANK
                                                             : seg7(w_bcd_shift[11:8]);
                        r_hex3 <= r_ovf     ? SEG_E
                                : r_neg_int ? SEG_MINUS
                                :             SEG_BLANK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy = (r_state != S_IDLE);
    assign bus.o_done = (r_state == S_DONE);
    assign bus.o_neg  = r_neg;
    assign bus.o_bcd  = r_bcd;
    assign bus.o_hex0 = r_hex0;
    assign bus.o_hex1 = r_hex1;
    assign bus.o_hex2 = r_hex2;
    assign bus.o_hex3 = r_hex3;
endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: conversions with hand-computed BCD and
// segment patterns, latency/handshake timing, held Load and reset mid-shift.
module tb_sum_bcd_display;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] D0    = 7'b1000000;
    localparam logic [6:0] D1    = 7'b1111001;
    localparam logic [6:0] D2    = 7'b0100100;
    localparam logic [6:0] D5    = 7'b0010010;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n;
    int   dones;

    sum_bcd_display_if #(.WIDTH(8), .DIGITS(3)) bus ();

    sum_bcd_display #(.WIDTH(8), .DIGITS(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pulse Load for one cycle; report cycles from the sampling edge to Done.
    task automatic convert(input logic [7:0] v, input logic sg, input logic ov,
                           output int lat);
        @(posedge clk); #1;
        bus.i_load = 1'b1; bus.i_value = v; bus.i_signed = sg; bus.i_ovf = ov;
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        @(negedge clk);
        chk("busy_cycle1", 32'(bus.o_busy), 32'd1);
        lat = 1;
        while (!bus.o_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_result(input string tag, input logic [11:0] bcd, input logic neg,
                              input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0);
        $display("result %s", tag);
        chk("bcd",  32'(bus.o_bcd),  32'(bcd));
        chk("neg",  32'(bus.o_neg),  32'(neg));
        chk("hex3", 32'(bus.o_hex3), 32'(h3));
        chk("hex2", 32'(bus.o_hex2), 32'(h2));
        chk("hex1", 32'(bus.o_hex1), 32'(h1));
        chk("hex0", 32'(bus.o_hex0), 32'(h0));
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.i_load = 1'b0; bus.i_value = '0; bus.i_signed = 1'b0; bus.i_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk_result("reset", 12'h000, 1'b0, BLANK, BLANK, BLANK, D0);
        rst_n = 1'b1;

        // Unsigned 8'hFF -> 255, Done in cycle 10, pulse lasts one cycle.
        convert(8'hFF, 1'b0, 1'b0, n);
        chk("latency_ff", 32'(n), 32'd10);
        chk("done_ff", 32'(bus.o_done), 32'd1);
        chk_result("u_ff", 12'h255, 1'b0, BLANK, D2, D5, D5);
        @(negedge clk);
        chk("done_pulse", 32'(bus.o_done), 32'd0);
        chk("busy_idle", 32'(bus.o_busy), 32'd0);
        chk("hold_bcd", 32'(bus.o_bcd), 32'h255);

        // Signed 8'h80 -> -128.
        convert(8'h80, 1'b1, 1'b0, n);
        chk("latency_80", 32'(n), 32'd10);
        chk_result("s_80", 12'h128, 1'b1, MINUS, D1, D2, 7'b0000000);

        // Signed 8'hF6 -> -10: hundreds blanked, tens shown.
        convert(8'hF6, 1'b1, 1'b0, n);
        chk_result("s_f6", 12'h010, 1'b1, MINUS, BLANK, D1, D0);

        // Signed zero: no "-0", only the ones digit lit.
        convert(8'h00, 1'b1, 1'b0, n);
        chk_result("s_00", 12'h000, 1'b0, BLANK, BLANK, BLANK, D0);

        // Unsigned 100: tens zero is not blanked when hundreds is nonzero.
        convert(8'h64, 1'b0, 1'b0, n);
        chk_result("u_100", 12'h100, 1'b0, BLANK, D1, D0, D0);

        // Signed 8'h7F with overflow: 'E' wins, value still converted.
        convert(8'h7F, 1'b1, 1'b1, n);
        chk_result("ovf_7f", 12'h127, 1'b0, SEG_E, D1, D2, 7'b1111000);

        // Load held high, Value changes mid-conversion.
        @(posedge clk); #1;
        bus.i_load = 1'b1; bus.i_value = 8'd42; bus.i_signed = 1'b0; bus.i_ovf = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 bus.i_value = 8'd153;
        n = 0;
        while (!bus.o_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_done", 32'(bus.o_done), 32'd1);
        chk("hold_first", 32'(bus.o_bcd), 32'h042);
        @(negedge clk);
        chk("hold_idle", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        chk("hold_recap", 32'(bus.o_busy), 32'd1);
        @(posedge clk); #1 bus.i_load = 1'b0;
        n = 0;
        while (!bus.o_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_lat2", 32'(n), 32'd9);
        chk("hold_second", 32'(bus.o_bcd), 32'h153);

        // Reset during SHIFT: immediate reset values, no Done afterwards.
        @(posedge clk); #1;
        bus.i_load = 1'b1; bus.i_value = 8'd77; bus.i_signed = 1'b0;
        @(posedge clk); #1 bus.i_load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_done", 32'(bus.o_done), 32'd0);
        chk_result("mid_rst", 12'h000, 1'b0, BLANK, BLANK, BLANK, D0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        chk("no_done_after", 32'(dones), 32'd0);
        chk("post_rst_bcd", 32'(bus.o_bcd), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
